// File: rtl/dmem_pkg.sv
// Shared size codes, FSM states and load-extension helper for the byte-lane data memory.
package dmem_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE  = 2'd0,
        SZ_HALF  = 2'd1,
        SZ_WORD  = 2'd2,
        SZ_DWORD = 2'd3
    } size_e;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_IDLE = 1'b1
    } state_e;

    localparam int MAX_DW = 512;

    // Keeps the low 'width' bits of field; every bit above is the field MSB (sign_ext) or zero.
    function automatic logic [MAX_DW-1:0] extend_field(
        input logic [MAX_DW-1:0] field,
        input int                width,
        input logic              sign_ext
    );
        logic [MAX_DW-1:0] result;
        logic              msb;
        result = '0;
        msb    = 1'b0;
        for (int i = 0; i < MAX_DW; i++) begin
            if (i < width) begin
                result[i] = field[i];
                msb       = field[i];
            end else begin
                result[i] = sign_ext & msb;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/dmem_bank.sv
// Lane-writable synchronous RAM with a registered read-first output; storage is never reset.
module dmem_bank #(
    parameter int B     = 8,
    parameter int L     = 4,
    parameter int WORDS = 64,
    parameter int AW    = 6
) (
    input  logic           clk,
    input  logic [L-1:0]   lane_we,
    input  logic [AW-1:0]  addr,
    input  logic [L*B-1:0] wdata,
    output logic [L*B-1:0] rdata
);

    logic [L*B-1:0] mem [WORDS];

    always_ff @(posedge clk) begin
        for (int i = 0; i < L; i++) begin
            if (lane_we[i]) begin
                mem[addr][i*B +: B] <= wdata[i*B +: B];
            end
        end
        rdata <= mem[addr];
    end

endmodule

// File: rtl/dmem_lane.sv
// Byte-lane data memory: clear sweep after reset, aligned byte/half/word access,
// two-stage pipeline (array read, then lane shift/extend into the response registers).
module dmem_lane
    import dmem_pkg::*;
#(
    parameter int B = 8,
    parameter int N = 8,
    parameter int L = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           req_valid,
    output logic           req_ready,
    input  logic           req_we,
    input  logic [N-1:0]   req_addr,
    input  logic [1:0]     req_size,
    input  logic           req_signed,
    input  logic [L*B-1:0] req_wdata,
    output logic           rsp_valid,
    output logic [L*B-1:0] rsp_rdata,
    output logic           rsp_err,
    output logic           init_done
);

    localparam int LW    = $clog2(L);
    localparam int WORDS = (2 ** N) / L;
    localparam int AW    = N - LW;
    localparam int DW    = L * B;

    state_e          state_q;
    state_e          state_d;
    logic [AW-1:0]   sweep_cnt;
    logic            sweeping;

    logic            accept;
    logic [AW-1:0]   acc_word;
    logic [LW-1:0]   acc_off;
    int              acc_bytes;
    logic            acc_err;
    logic [L-1:0]    store_lanes;
    logic [DW-1:0]   store_data;

    logic [L-1:0]    bank_we;
    logic [AW-1:0]   bank_addr;
    logic [DW-1:0]   bank_wdata;
    logic [DW-1:0]   bank_rdata;

    logic            s1_valid;
    logic            s1_we;
    logic            s1_err;
    logic            s1_signed;
    logic [LW-1:0]   s1_off;
    logic [1:0]      s1_size;
    logic [DW-1:0]   load_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_INIT;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        req_ready = 1'b0;
        init_done = 1'b0;
        sweeping  = 1'b0;
        case (state_q)
            ST_INIT: begin
                sweeping = 1'b1;
                if (sweep_cnt == AW'(WORDS - 1)) begin
                    state_d = ST_IDLE;
                end
            end
            ST_IDLE: begin
                req_ready = 1'b1;
                init_done = 1'b1;
            end
            default: state_d = ST_INIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sweep_cnt <= '0;
        end else if (sweeping) begin
            sweep_cnt <= sweep_cnt + 1'b1;
        end
    end

    assign accept = req_valid && req_ready;

    // An access is legal only if it fits in a word and starts on a multiple of its own size.
    always_comb begin
        acc_word    = req_addr[N-1:LW];
        acc_off     = req_addr[LW-1:0];
        acc_bytes   = 1 << req_size;
        acc_err     = (acc_bytes > L) || ((int'(acc_off) & (acc_bytes - 1)) != 0);
        store_data  = req_wdata << (int'(acc_off) * B);
        store_lanes = '0;
        for (int i = 0; i < L; i++) begin
            if ((i >= int'(acc_off)) && (i < int'(acc_off) + acc_bytes)) begin
                store_lanes[i] = 1'b1;
            end
        end
    end

    always_comb begin
        bank_we    = '0;
        bank_addr  = acc_word;
        bank_wdata = store_data;
        if (sweeping) begin
            bank_we    = '1;
            bank_addr  = sweep_cnt;
            bank_wdata = '0;
        end else if (accept && req_we && !acc_err && !rst) begin
            bank_we = store_lanes;
        end
    end

    dmem_bank #(
        .B     (B),
        .L     (L),
        .WORDS (WORDS),
        .AW    (AW)
    ) u_bank (
        .clk     (clk),
        .lane_we (bank_we),
        .addr    (bank_addr),
        .wdata   (bank_wdata),
        .rdata   (bank_rdata)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
        end else begin
            s1_valid <= accept;
        end
        if (accept) begin
            s1_we     <= req_we;
            s1_err    <= acc_err;
            s1_signed <= req_signed;
            s1_off    <= acc_off;
            s1_size   <= req_size;
        end
    end

    always_comb begin
        load_data = DW'(extend_field(MAX_DW'(bank_rdata >> (int'(s1_off) * B)),
                                     (1 << s1_size) * B, s1_signed));
    end

    // Data is forced to zero for stores and errors and otherwise held while no response is due.
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            rsp_valid <= s1_valid;
            if (s1_valid) begin
                rsp_err   <= s1_err;
                rsp_rdata <= (s1_err || s1_we) ? '0 : load_data;
            end
        end
    end

endmodule

// File: tb/tb_dmem_lane.sv
// Scoreboard bench for dmem_lane: directed loads/stores push hand-computed responses,
// a negedge monitor pops and compares data, error flag and arrival cycle.
module tb_dmem_lane;
    import dmem_pkg::*;

    localparam int B  = 8;
    localparam int N  = 8;
    localparam int L  = 4;
    localparam int DW = 32;

    logic          clk;
    logic          rst;
    logic          req_valid;
    logic          req_ready;
    logic          req_we;
    logic [N-1:0]  req_addr;
    logic [1:0]    req_size;
    logic          req_signed;
    logic [DW-1:0] req_wdata;
    logic          rsp_valid;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_err;
    logic          init_done;

    typedef struct {
        logic [DW-1:0] data;
        logic          err;
        int            cyc;
        string         name;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   tests = 0;
    int   fails = 0;
    int   cyc   = 0;

    dmem_lane #(.B(B), .N(N), .L(L)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_addr   (req_addr),
        .req_size   (req_size),
        .req_signed (req_signed),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err),
        .init_done  (init_done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        tests++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Monitor: every response must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rsp_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("[TB] FAIL unexpected_rsp: got rsp_valid 1 at cycle %0d, expected none", cyc);
            end else begin
                mon_e = exp_q.pop_front();
                checkOutput({mon_e.name, "_data"}, 64'(rsp_rdata), 64'(mon_e.data));
                checkOutput({mon_e.name, "_err"}, 64'(rsp_err), 64'(mon_e.err));
                checkOutput({mon_e.name, "_cycle"}, 64'(cyc), 64'(mon_e.cyc));
            end
        end
    end

    task automatic applyStimulus(input string name, input logic we, input logic [N-1:0] addr,
                                 input logic [1:0] size, input logic sgn, input logic [DW-1:0] wdata,
                                 input logic exp_err, input logic [DW-1:0] exp_data);
        exp_t e;
        @(negedge clk);
        checkOutput({name, "_ready"}, 64'(req_ready), 64'd1);
        req_valid  = 1'b1;
        req_we     = we;
        req_addr   = addr;
        req_size   = size;
        req_signed = sgn;
        req_wdata  = wdata;
        e.data = exp_data;
        e.err  = exp_err;
        e.cyc  = cyc + 2;
        e.name = name;
        exp_q.push_back(e);
    endtask

    task automatic storeOp(input string name, input logic [N-1:0] addr, input logic [1:0] size,
                           input logic [DW-1:0] wdata, input logic exp_err);
        applyStimulus(name, 1'b1, addr, size, 1'b0, wdata, exp_err, '0);
    endtask

    task automatic loadOp(input string name, input logic [N-1:0] addr, input logic [1:0] size,
                          input logic sgn, input logic exp_err, input logic [DW-1:0] exp_data);
        applyStimulus(name, 1'b0, addr, size, sgn, '0, exp_err, exp_data);
    endtask

    task automatic endStimulus();
        @(negedge clk);
        req_valid = 1'b0;
        req_we    = 1'b0;
    endtask

    task automatic waitDrain();
        int n = 0;
        while (exp_q.size() != 0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        checkOutput("drain_pending", 64'(exp_q.size()), 64'd0);
    endtask

    // Called at the first negedge after the last reset edge; expects 64 busy cycles.
    task automatic waitInit(input string name);
        int bad = 0;
        for (int i = 0; i < 64; i++) begin
            if (req_ready !== 1'b0 || init_done !== 1'b0) bad++;
            @(negedge clk);
        end
        checkOutput({name, "_busy_violations"}, 64'(bad), 64'd0);
        checkOutput({name, "_ready"}, 64'(req_ready), 64'd1);
        checkOutput({name, "_done"}, 64'(init_done), 64'd1);
    endtask

    initial begin
        rst        = 1'b1;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_addr   = '0;
        req_size   = SZ_BYTE;
        req_signed = 1'b0;
        req_wdata  = '0;
        repeat (3) @(negedge clk);
        checkOutput("rst_ready", 64'(req_ready), 64'd0);
        checkOutput("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        checkOutput("rst_rsp_rdata", 64'(rsp_rdata), 64'd0);
        checkOutput("rst_rsp_err", 64'(rsp_err), 64'd0);
        checkOutput("rst_init_done", 64'(init_done), 64'd0);
        rst = 1'b0;
        waitInit("init");

        loadOp("init_ld00", 8'h00, SZ_WORD, 1'b0, 1'b0, 32'h0);
        loadOp("init_ld3c", 8'h3C, SZ_WORD, 1'b0, 1'b0, 32'h0);
        loadOp("init_ldfc", 8'hFC, SZ_WORD, 1'b0, 1'b0, 32'h0);
        endStimulus();
        waitDrain();

        storeOp("st_b13", 8'h13, SZ_BYTE, 32'h0000_0085, 1'b0);
        loadOp("ld_b13_s", 8'h13, SZ_BYTE, 1'b1, 1'b0, 32'hFFFF_FF85);
        loadOp("ld_b13_u", 8'h13, SZ_BYTE, 1'b0, 1'b0, 32'h0000_0085);
        loadOp("ld_w10", 8'h10, SZ_WORD, 1'b0, 1'b0, 32'h8500_0000);
        endStimulus();
        waitDrain();

        storeOp("st_w20", 8'h20, SZ_WORD, 32'h1122_3344, 1'b0);
        storeOp("st_h22", 8'h22, SZ_HALF, 32'h0000_BEEF, 1'b0);
        loadOp("ld_w20", 8'h20, SZ_WORD, 1'b0, 1'b0, 32'hBEEF_3344);
        loadOp("ld_h22_s", 8'h22, SZ_HALF, 1'b1, 1'b0, 32'hFFFF_BEEF);
        loadOp("ld_h20_u", 8'h20, SZ_HALF, 1'b0, 1'b0, 32'h0000_3344);
        loadOp("ld_b21_s", 8'h21, SZ_BYTE, 1'b1, 1'b0, 32'h0000_0033);
        loadOp("ld_b23_u", 8'h23, SZ_BYTE, 1'b0, 1'b0, 32'h0000_00BE);
        loadOp("ld_w20_s", 8'h20, SZ_WORD, 1'b1, 1'b0, 32'hBEEF_3344);
        endStimulus();
        waitDrain();

        storeOp("st_h21_mis", 8'h21, SZ_HALF, 32'h0000_AAAA, 1'b1);
        loadOp("ld_w20_after", 8'h20, SZ_WORD, 1'b0, 1'b0, 32'hBEEF_3344);
        loadOp("ld_w22_mis", 8'h22, SZ_WORD, 1'b0, 1'b1, 32'h0);
        loadOp("ld_d00_size", 8'h00, SZ_DWORD, 1'b0, 1'b1, 32'h0);
        endStimulus();
        waitDrain();

        storeOp("b2b_st40", 8'h40, SZ_WORD, 32'hCAFE_F00D, 1'b0);
        loadOp("b2b_ld40", 8'h40, SZ_WORD, 1'b0, 1'b0, 32'hCAFE_F00D);
        storeOp("b2b_st44", 8'h44, SZ_WORD, 32'h1234_5678, 1'b0);
        loadOp("b2b_ld44", 8'h44, SZ_WORD, 1'b0, 1'b0, 32'h1234_5678);
        endStimulus();
        waitDrain();

        for (int i = 0; i < 16; i++) begin
            storeOp($sformatf("fill%0d", i), 8'(i * 4), SZ_WORD, 32'hA500_0000 | 32'(i), 1'b0);
        end
        loadOp("fill_ld3c", 8'h3C, SZ_WORD, 1'b0, 1'b0, 32'hA500_000F);
        endStimulus();
        waitDrain();

        // Load accepted, then reset lands on the edge that would launch its response.
        @(negedge clk);
        req_valid  = 1'b1;
        req_we     = 1'b0;
        req_addr   = 8'h3C;
        req_size   = SZ_WORD;
        req_signed = 1'b0;
        @(negedge clk);
        req_valid = 1'b0;
        rst       = 1'b1;
        @(negedge clk);
        checkOutput("rst_kills_rsp", 64'(rsp_valid), 64'd0);
        rst = 1'b0;
        waitInit("reinit");

        for (int i = 0; i < 17; i++) begin
            loadOp($sformatf("clr_ld%0d", i), 8'(i * 4), SZ_WORD, 1'b0, 1'b0, 32'h0);
        end
        endStimulus();
        waitDrain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #100000;
        tests++;
        fails++;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
